// File: rtl/fetch_scan_seq.sv
// Fetch-block sequencer: walks each 64-bit block one halfword at a time and emits realigned RVI/RVC instructions.
// It stitches instructions that straddle two blocks and redirects on direct jumps.

module instr_scan (
  input  logic [31:0] instr,
  output logic        is_rvc,
  output logic        rvi_return,
  output logic        rvi_call,
  output logic        rvi_branch,
  output logic        rvi_jalr,
  output logic        rvi_jump,
  output logic [63:0] rvi_imm,
  output logic        rvc_branch,
  output logic        rvc_jump,
  output logic        rvc_jr,
  output logic        rvc_return,
  output logic        rvc_jalr,
  output logic        rvc_call,
  output logic [63:0] rvc_imm
);
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [2:0]  c_funct3;
  logic        rd_link;
  logic        rs1_link;
  logic        c_rs1_link;
  logic        c_q1;
  logic        c_q2;
  logic        c_jal_enc;
  logic [63:0] b_imm;
  logic [63:0] j_imm;
  logic [63:0] i_imm;
  logic [63:0] cj_imm;
  logic [63:0] cb_imm;

  assign opcode     = instr[6:0];
  assign rd         = instr[11:7];
  assign rs1        = instr[19:15];
  assign c_funct3   = instr[15:13];
  assign is_rvc     = (instr[1:0] != 2'b11);
  assign rd_link    = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link   = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign c_rs1_link = (instr[11:7] == 5'd1) || (instr[11:7] == 5'd5);

  assign b_imm  = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j_imm  = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign i_imm  = {{52{instr[31]}}, instr[31:20]};
  assign cj_imm = {{52{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
  assign cb_imm = {{55{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};

  assign rvi_branch = !is_rvc && (opcode == 7'h63);
  assign rvi_jalr   = !is_rvc && (opcode == 7'h67);
  assign rvi_jump   = !is_rvc && (opcode == 7'h6F);
  assign rvi_call   = (rvi_jalr || rvi_jump) && rd_link;
  assign rvi_return = rvi_jalr && rs1_link && (rd == 5'd0);

  always_comb begin
    rvi_imm = 64'd0;
    if (rvi_jump)        rvi_imm = j_imm;
    else if (rvi_branch) rvi_imm = b_imm;
    else if (rvi_jalr)   rvi_imm = i_imm;
  end

  // Quadrant 1 holds C.J/C.JAL/C.BEQZ/C.BNEZ; quadrant 2 holds C.JR/C.JALR (rs2 == 0, rs1 != 0).
  assign c_q1       = (instr[1:0] == 2'b01);
  assign c_q2       = (instr[1:0] == 2'b10);
  assign c_jal_enc  = c_q1 && (c_funct3 == 3'b001);
  assign rvc_jump   = c_q1 && ((c_funct3 == 3'b101) || (c_funct3 == 3'b001));
  assign rvc_branch = c_q1 && ((c_funct3 == 3'b110) || (c_funct3 == 3'b111));
  assign rvc_jr     = c_q2 && (instr[15:12] == 4'b1000) && (instr[6:2] == 5'd0) && (instr[11:7] != 5'd0);
  assign rvc_jalr   = c_q2 && (instr[15:12] == 4'b1001) && (instr[6:2] == 5'd0) && (instr[11:7] != 5'd0);
  assign rvc_return = rvc_jr && c_rs1_link;
  assign rvc_call   = rvc_jalr || c_jal_enc;

  always_comb begin
    rvc_imm = 64'd0;
    if (rvc_jump)        rvc_imm = cj_imm;
    else if (rvc_branch) rvc_imm = cb_imm;
  end
endmodule

module fetch_scan_seq #(
  parameter int VLEN   = 64,
  parameter int BLK_HW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [63:0]     fetch_data_i,
  input  logic [VLEN-1:0] fetch_addr_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [VLEN-1:0] instr_addr_o,
  output logic [2:0]      instr_cf_o,
  output logic [63:0]     instr_imm_o,
  output logic            redirect_valid_o,
  output logic [VLEN-1:0] redirect_addr_o
);
  typedef enum logic [1:0] {IDLE, SCAN, WAIT_UPPER, REDIR} state_t;

  state_t          state_reg;
  logic [63:0]     data_reg;
  logic [VLEN-4:0] blk_reg;
  logic [2:0]      hw_reg;
  logic            stitch_reg;
  logic [15:0]     saved_hw_reg;
  logic [VLEN-1:0] saved_pc_reg;
  logic [VLEN-1:0] expect_reg;
  logic            redirect_valid_reg;
  logic [VLEN-1:0] redirect_addr_reg;

  logic [15:0]     hw_arr [BLK_HW];
  logic [1:0]      cur_idx;
  logic [1:0]      nxt_idx;
  logic [15:0]     cur_hw;
  logic            cur_is32;
  logic            straddle;
  logic [31:0]     raw_instr;
  logic [VLEN-1:0] cur_pc;
  logic [VLEN-1:0] next_blk_addr;
  logic [2:0]      hw_step;
  logic [2:0]      hw_adv;
  logic            fetch_fire;
  logic            instr_fire;

  logic        is_rvc, rvi_return, rvi_call, rvi_branch, rvi_jalr, rvi_jump;
  logic        rvc_branch, rvc_jump, rvc_jr, rvc_return, rvc_jalr, rvc_call;
  logic [63:0] rvi_imm, rvc_imm;
  logic        is_ret, is_call, is_jalr, is_jump, is_branch;
  logic [2:0]  cf;
  logic [63:0] imm_sel;

  for (genvar gi = 0; gi < BLK_HW; gi++) begin : g_hw
    assign hw_arr[gi] = data_reg[16*gi +: 16];
  end

  assign cur_idx       = hw_reg[1:0];
  assign nxt_idx       = cur_idx + 2'd1;
  assign cur_hw        = hw_arr[cur_idx];
  assign cur_is32      = (cur_hw[1:0] == 2'b11);
  assign next_blk_addr = {blk_reg + (VLEN-3)'(1), 3'b000};
  // The upper half of a 32-bit instruction in the last halfword lives in the next block.
  assign straddle      = (state_reg == SCAN) && !stitch_reg && cur_is32 && (cur_idx == 2'd3);

  always_comb begin
    raw_instr = {16'h0000, cur_hw};
    cur_pc    = {blk_reg, cur_idx, 1'b0};
    hw_step   = 3'd1;
    if (stitch_reg) begin
      raw_instr = {hw_arr[0], saved_hw_reg};
      cur_pc    = saved_pc_reg;
      hw_step   = 3'd0;
    end else if (cur_is32) begin
      raw_instr = {hw_arr[nxt_idx], cur_hw};
      hw_step   = 3'd2;
    end
  end
  assign hw_adv = hw_reg + hw_step;

  instr_scan u_scan (
    .instr      (raw_instr),
    .is_rvc     (is_rvc),
    .rvi_return (rvi_return),
    .rvi_call   (rvi_call),
    .rvi_branch (rvi_branch),
    .rvi_jalr   (rvi_jalr),
    .rvi_jump   (rvi_jump),
    .rvi_imm    (rvi_imm),
    .rvc_branch (rvc_branch),
    .rvc_jump   (rvc_jump),
    .rvc_jr     (rvc_jr),
    .rvc_return (rvc_return),
    .rvc_jalr   (rvc_jalr),
    .rvc_call   (rvc_call),
    .rvc_imm    (rvc_imm)
  );

  assign is_ret    = is_rvc ? rvc_return : rvi_return;
  assign is_call   = is_rvc ? rvc_call : rvi_call;
  assign is_jalr   = is_rvc ? (rvc_jr || rvc_jalr) : rvi_jalr;
  assign is_jump   = is_rvc ? rvc_jump : rvi_jump;
  assign is_branch = is_rvc ? rvc_branch : rvi_branch;
  assign imm_sel   = is_rvc ? rvc_imm : rvi_imm;

  always_comb begin
    cf = 3'd0;
    if (is_ret)         cf = 3'd5;
    else if (is_call)   cf = 3'd4;
    else if (is_jalr)   cf = 3'd3;
    else if (is_jump)   cf = 3'd2;
    else if (is_branch) cf = 3'd1;
  end

  assign fetch_ready_o    = !rst_i && !flush_i && ((state_reg == IDLE) || (state_reg == WAIT_UPPER));
  assign fetch_fire       = fetch_valid_i && fetch_ready_o;
  assign instr_valid_o    = !rst_i && (state_reg == SCAN) && !straddle;
  assign instr_fire       = instr_valid_o && instr_ready_i;
  assign instr_o          = instr_valid_o ? raw_instr : 32'd0;
  assign instr_addr_o     = instr_valid_o ? cur_pc : '0;
  assign instr_cf_o       = instr_valid_o ? cf : 3'd0;
  assign instr_imm_o      = (instr_valid_o && (cf != 3'd0)) ? imm_sel : 64'd0;
  assign redirect_valid_o = !rst_i && redirect_valid_reg;
  assign redirect_addr_o  = redirect_valid_o ? redirect_addr_reg : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_reg          <= IDLE;
      data_reg           <= '0;
      blk_reg            <= '0;
      hw_reg             <= '0;
      stitch_reg         <= 1'b0;
      saved_hw_reg       <= '0;
      saved_pc_reg       <= '0;
      expect_reg         <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fetch_fire) begin
            data_reg   <= fetch_data_i;
            blk_reg    <= fetch_addr_i[VLEN-1:3];
            hw_reg     <= {1'b0, fetch_addr_i[2:1]};
            stitch_reg <= 1'b0;
            state_reg  <= SCAN;
          end
        end
        SCAN: begin
          if (straddle) begin
            saved_hw_reg <= cur_hw;
            saved_pc_reg <= cur_pc;
            expect_reg   <= next_blk_addr;
            state_reg    <= WAIT_UPPER;
          end else if (instr_fire) begin
            stitch_reg <= 1'b0;
            if (is_jump) begin
              redirect_valid_reg <= 1'b1;
              redirect_addr_reg  <= cur_pc + imm_sel[VLEN-1:0];
              state_reg          <= REDIR;
            end else begin
              hw_reg <= hw_adv;
              if (hw_adv[2]) state_reg <= IDLE;
            end
          end
        end
        WAIT_UPPER: begin
          if (fetch_fire) begin
            data_reg  <= fetch_data_i;
            blk_reg   <= fetch_addr_i[VLEN-1:3];
            state_reg <= SCAN;
            if (fetch_addr_i == expect_reg) begin
              hw_reg     <= 3'd1;
              stitch_reg <= 1'b1;
            end else begin
              // Non-sequential block: the saved lower half is stale, start fresh.
              hw_reg       <= {1'b0, fetch_addr_i[2:1]};
              stitch_reg   <= 1'b0;
              saved_hw_reg <= '0;
              saved_pc_reg <= '0;
            end
          end
        end
        REDIR: begin
          redirect_valid_reg <= 1'b0;
          state_reg          <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_scan_seq.sv
// Scoreboard bench for fetch_scan_seq: expected instructions and redirects are queued at
// stimulus time and compared when the DUT emits them.

module tb_fetch_scan_seq;
  localparam int VLEN = 64;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [63:0]     fetch_data_i;
  logic [VLEN-1:0] fetch_addr_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic [VLEN-1:0] instr_addr_o;
  logic [2:0]      instr_cf_o;
  logic [63:0]     instr_imm_o;
  logic            redirect_valid_o;
  logic [VLEN-1:0] redirect_addr_o;

  always #5 clk_i = ~clk_i;

  fetch_scan_seq #(.VLEN(VLEN), .BLK_HW(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_ready_o    (fetch_ready_o),
    .fetch_data_i     (fetch_data_i),
    .fetch_addr_i     (fetch_addr_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_addr_o     (instr_addr_o),
    .instr_cf_o       (instr_cf_o),
    .instr_imm_o      (instr_imm_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_addr_o  (redirect_addr_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic [2:0]  cf;
    logic [63:0] imm;
  } exp_t;

  exp_t        instr_q[$];
  logic [63:0] redir_q[$];
  exp_t        mon_e;
  logic [63:0] mon_r;
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_instr(input logic [31:0] instr, input logic [63:0] addr,
                            input logic [2:0] cf, input logic [63:0] imm);
    exp_t e;
    e.instr = instr;
    e.addr  = addr;
    e.cf    = cf;
    e.imm   = imm;
    instr_q.push_back(e);
  endtask

  task automatic push_nops(input logic [63:0] base, input int first, input int n);
    for (int k = 0; k < n; k++) push_instr(32'h0000_0001, base + 64'(2 * (first + k)), 3'd0, 64'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_block(input logic [63:0] addr, input logic [63:0] data);
    logic hs;
    hs            = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_addr_i  = addr;
    fetch_data_i  = data;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk_i);
      hs = fetch_ready_o;
      @(posedge clk_i);
      #1;
    end
    fetch_valid_i = 1'b0;
    check("fetch_accept", 64'(hs), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (instr_q.size() != 0 || redir_q.size() != 0); i++) @(posedge clk_i);
    repeat (2) @(posedge clk_i);
    #1;
    check("drain", 64'(instr_q.size() + redir_q.size()), 64'd0);
  endtask

  always @(negedge clk_i) begin
    if (instr_valid_o && instr_ready_i) begin
      check("instr_expected", 64'(instr_q.size() != 0), 64'd1);
      if (instr_q.size() != 0) begin
        mon_e = instr_q.pop_front();
        check("instr", 64'(instr_o), 64'(mon_e.instr));
        check("instr_addr", instr_addr_o, mon_e.addr);
        check("instr_cf", 64'(instr_cf_o), 64'(mon_e.cf));
        check("instr_imm", instr_imm_o, mon_e.imm);
        $display("instr %08h @%h cf=%0d imm=%h", instr_o, instr_addr_o, instr_cf_o, instr_imm_o);
      end
    end
    if (redirect_valid_o) begin
      check("redirect_expected", 64'(redir_q.size() != 0), 64'd1);
      if (redir_q.size() != 0) begin
        mon_r = redir_q.pop_front();
        check("redirect_addr", redirect_addr_o, mon_r);
        $display("redirect -> %h", redirect_addr_o);
      end
    end
  end

  initial begin
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = '0;
    fetch_addr_i  = '0;
    instr_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_fetch_ready", 64'(fetch_ready_o), 64'd0);
    check("rst_instr_valid", 64'(instr_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_fetch_ready", 64'(fetch_ready_o), 64'd1);
    check("idle_instr_valid", 64'(instr_valid_o), 64'd0);
    check("idle_instr", 64'(instr_o), 64'd0);
    check("idle_redirect", 64'(redirect_valid_o), 64'd0);
    @(posedge clk_i);
    #1;

    // Four RVC NOPs, one per cycle.
    push_nops(64'h1000, 0, 4);
    send_block(64'h1000, 64'h0001_0001_0001_0001);
    wait_drain();
    check("idle_after_block", 64'(fetch_ready_o), 64'd1);

    // Start mid-block: only the addi in halfwords 2-3.
    push_instr(32'h0000_0013, 64'h2004, 3'd0, 64'd0);
    send_block(64'h2004, 64'h0000_0013_0001_0001);
    wait_drain();

    // Straddling addi stitched across sequential blocks.
    push_nops(64'h3000, 0, 3);
    push_instr(32'h0000_0013, 64'h3006, 3'd0, 64'd0);
    push_nops(64'h3008, 1, 3);
    send_block(64'h3000, 64'h0013_0001_0001_0001);
    send_block(64'h3008, 64'h0001_0001_0001_0000);
    wait_drain();

    // Non-sequential second block: saved halfword dropped.
    push_nops(64'h3000, 0, 3);
    push_nops(64'h4000, 0, 4);
    send_block(64'h3000, 64'h0013_0001_0001_0001);
    send_block(64'h4000, 64'h0001_0001_0001_0001);
    wait_drain();

    // JAL x1,+0x100: call, redirect, trailing NOPs discarded.
    push_instr(32'h1000_00EF, 64'h5000, 3'd4, 64'h100);
    redir_q.push_back(64'h5100);
    send_block(64'h5000, 64'h0001_0001_1000_00EF);
    wait_drain();

    // C.JR x1 (return), BEQ +8 (branch), NOP: no redirect.
    push_instr(32'h0000_8082, 64'h6000, 3'd5, 64'd0);
    push_instr(32'h0000_0463, 64'h6002, 3'd1, 64'd8);
    push_instr(32'h0000_0001, 64'h6006, 3'd0, 64'd0);
    send_block(64'h6000, 64'h0001_0000_0463_8082);
    wait_drain();

    // C.J +4 at halfword 1.
    push_instr(32'h0000_0001, 64'h7000, 3'd0, 64'd0);
    push_instr(32'h0000_A011, 64'h7002, 3'd2, 64'd4);
    redir_q.push_back(64'h7006);
    send_block(64'h7000, 64'h0001_0001_A011_0001);
    wait_drain();

    // Consumer stall for 3 cycles mid-block.
    push_nops(64'h8000, 0, 4);
    send_block(64'h8000, 64'h0001_0001_0001_0001);
    @(posedge clk_i);
    #1;
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("stall_valid", 64'(instr_valid_o), 64'd1);
      check("stall_addr", instr_addr_o, 64'h8002);
      check("stall_instr", 64'(instr_o), 64'h0001);
    end
    @(posedge clk_i);
    #1;
    instr_ready_i = 1'b1;
    wait_drain();

    // Flush mid-block.
    push_nops(64'h9000, 0, 1);
    send_block(64'h9000, 64'h0001_0001_0001_0001);
    @(posedge clk_i);
    #1;
    instr_ready_i = 1'b0;
    flush_i       = 1'b1;
    @(negedge clk_i);
    check("flush_fetch_ready", 64'(fetch_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_valid", 64'(instr_valid_o), 64'd0);
    check("flush_redirect", 64'(redirect_valid_o), 64'd0);
    check("flush_idle", 64'(fetch_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    instr_ready_i = 1'b1;
    wait_drain();

    // Reset while waiting for the upper half.
    push_nops(64'hA000, 0, 3);
    send_block(64'hA000, 64'h0013_0001_0001_0001);
    begin
      logic reached;
      reached = 1'b0;
      for (int i = 0; i < 50 && !reached; i++) begin
        @(negedge clk_i);
        reached = fetch_ready_o;
      end
      check("wait_upper_reached", 64'(reached), 64'd1);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst2_fetch_ready", 64'(fetch_ready_o), 64'd0);
    check("rst2_instr_valid", 64'(instr_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst2_idle", 64'(fetch_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    push_nops(64'hA008, 0, 4);
    send_block(64'hA008, 64'h0001_0001_0001_0001);
    wait_drain();

    check("sb_instr_empty", 64'(instr_q.size()), 64'd0);
    check("sb_redir_empty", 64'(redir_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
